load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  - Core-side load/store unit sitting directly upstream of the data RAM.
//  - Takes one load/store per transaction from the execute stage.
//  - Drives the data-memory req/gnt/rvalid bus: byte-enable encoding, write-lane replication, read extraction/extension.
//  - Detects misaligned accesses and response timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT_RV before a load aborts with error (>=2)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  lsu_valid_i    in   1   execute stage presents a request
//  lsu_ready_o    out  1   unit can accept (high only in IDLE)
//  lsu_we_i       in   1   1=store, 0=load
//  lsu_size_i     in   2   00=byte, 01=half, 10=word, 11=illegal
//  lsu_signed_i   in   1   sign-extend load result
//  lsu_addr_i     in   32  byte address
//  lsu_wdata_i    in   32  store data, right-justified
//  lsu_done_o     out  1   one-cycle pulse: transaction finished
//  lsu_err_o      out  1   valid with lsu_done_o: misaligned/illegal size/timeout
//  lsu_rdata_o    out  32  extended load data, valid with lsu_done_o
//  data_req_o     out  1   memory request
//  data_gnt_i     in   1   memory grant
//  data_rvalid_i  in   1   memory read data valid
//  data_addr_o    out  32  {addr[31:2],2'b00}
//  data_we_o      out  1   write enable
//  data_be_o      out  4   access encoding (see BEHAVIOUR)
//  data_wdata_o   out  32  replicated store data
//  data_rdata_i   in   32  memory read data
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0 except lsu_ready_o=1.
//  - Reset mid-transaction aborts immediately; no done pulse is issued.
//  - Accept: lsu_valid_i & lsu_ready_o.
//    - Register addr/we/size/signed/wdata; inputs are ignored outside IDLE.
//  - Alignment checks on accept:
//    - size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> no bus request.
//    - Next cycle: lsu_done_o=1, lsu_err_o=1, lsu_rdata_o=0; return to IDLE.
//  - FSM:
//    - IDLE -accept ok-> REQ.
//    - REQ: data_req_o=1. addr/we/be/wdata held stable until data_gnt_i.
//    - REQ -gnt & store-> DONE.
//    - REQ -gnt & load & rvalid-> DONE (gnt and rvalid in the same cycle: capture data then).
//    - REQ -gnt & load & !rvalid-> WAIT_RV.
//    - WAIT_RV: data_req_o=0. rvalid -> capture, DONE.
//    - WAIT_RV: counter reaches TIMEOUT_CYCLES -> DONE with err=1, rdata=0.
//    - DONE: lsu_done_o=1 for exactly one cycle -> IDLE.
//  - Latency, store: done 2 cycles after accept when gnt arrives in the first REQ cycle.
//  - Latency, load: done 1 cycle after rvalid.
//  - rvalid outside WAIT_RV / REQ-with-gnt is ignored.
//  - data_be_o encoding (off = addr[1:0]):
//    - word = 0001.
//    - half off0 = 0011, off2 = 0010.
//    - byte off0/1/2/3 = 1000/1001/1010/1100.
//  - Store data replication: byte -> {4{b}}; half -> {2{h}}; word -> as is.
//  - Load extraction:
//    - byte: off k -> rdata_i[8k+7:8k].
//    - half: off0 -> [15:0], off2 -> [31:16].
//    - word: [31:0].
//    - Result is zero- or sign-extended to 32 bits per lsu_signed_i.
//  - Timeout counter: clog2(TIMEOUT_CYCLES+1) bits, cleared on entering WAIT_RV, saturates.
// STRUCTURE
//  - Package lsu_pkg:
//    - lsu_size_e {SZ_BYTE, SZ_HALF, SZ_WORD}.
//    - BE_WORD/BE_HALF0/BE_HALF2/BE_BYTE0..3 constants.
//    - lsu_state_e {IDLE, REQ, WAIT_RV, DONE}.
//  - Sub-module lsu_align (combinational):
//    - Produces misaligned flag, data_be_o and replicated wdata.
//    - Produces extracted/extended read data.
//  - Top holds the FSM, registers and timeout counter.
// TESTING
//  - Store word 0xDEADBEEF @0x0010_0008, gnt same cycle:
//    - data_be_o=0001, data_addr_o=0x0010_0008.
//    - done 2 cycles after accept, err=0.
//  - Store byte 0xA5 @0x0010_0003: data_be_o=1100, data_wdata_o=0xA5A5A5A5.
//  - Load signed byte @0x0010_0001, rdata_i=0x0000_8000, rvalid 3 cycles after gnt:
//    - lsu_rdata_o=0xFFFF_FF80, done 1 cycle after rvalid.
//  - Load unsigned half @0x0010_0002, rdata_i=0x8001_0000: lsu_rdata_o=0x0000_8001.
//  - Load word @0x0010_0006: misaligned, data_req_o never asserts.
//    - done+err next cycle.
//  - Load with gnt held low 5 cycles, then no rvalid:
//    - data_req_o and data_addr_o stable for the 5 cycles.
//    - err after TIMEOUT_CYCLES in WAIT_RV.
//    - rst_n pulse mid-WAIT_RV returns to IDLE, ready=1, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared types and byte-enable constants for the load/store unit
// Revision: 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    // Access encoding carried on data_be_o, not a one-hot lane mask.
    localparam logic [3:0] BE_WORD  = 4'b0001;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF2 = 4'b0010;
    localparam logic [3:0] BE_BYTE0 = 4'b1000;
    localparam logic [3:0] BE_BYTE1 = 4'b1001;
    localparam logic [3:0] BE_BYTE2 = 4'b1010;
    localparam logic [3:0] BE_BYTE3 = 4'b1100;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        WAIT_RV = 2'b10,
        DONE    = 2'b11
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : alignment check, access encoding, store replication, load extend
// Revision: 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rsp_size_i,
    input  logic [1:0]  rsp_off_i,
    input  logic        rsp_signed_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);

    logic [31:0] w_shifted;

    always_comb begin
        misaligned_o = 1'b0;
        be_o         = BE_WORD;
        wdata_o      = req_wdata_i;
        case (req_size_i)
            SZ_BYTE: begin
                wdata_o = {4{req_wdata_i[7:0]}};
                case (req_off_i)
                    2'd0:    be_o = BE_BYTE0;
                    2'd1:    be_o = BE_BYTE1;
                    2'd2:    be_o = BE_BYTE2;
                    default: be_o = BE_BYTE3;
                endcase
            end
            SZ_HALF: begin
                wdata_o      = {2{req_wdata_i[15:0]}};
                be_o         = req_off_i[1] ? BE_HALF2 : BE_HALF0;
                misaligned_o = req_off_i[0];
            end
            SZ_WORD: misaligned_o = |req_off_i;
            default: misaligned_o = 1'b1;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign w_shifted = rsp_rdata_i >> {rsp_off_i, 3'b000};

    always_comb begin
        rsp_data_o = rsp_rdata_i;
        case (rsp_size_i)
            SZ_BYTE: rsp_data_o = {{24{rsp_signed_i & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: rsp_data_o = {{16{rsp_signed_i & w_shifted[15]}}, w_shifted[15:0]};
            default: rsp_data_o = rsp_rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : single-outstanding load/store engine on a req/gnt/rvalid bus
// Revision: 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_signed_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              signed_q, signed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rsp_data;

    lsu_align u_align (
        .req_size_i   (lsu_size_i),
        .req_off_i    (lsu_addr_i[1:0]),
        .req_wdata_i  (lsu_wdata_i),
        .misaligned_o (w_misaligned),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .rsp_size_i   (size_q),
        .rsp_off_i    (off_q),
        .rsp_signed_i (signed_q),
        .rsp_rdata_i  (data_rdata_i),
        .rsp_data_o   (w_rsp_data)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        off_d    = off_q;
        signed_d = signed_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = 32'h0;
        case (state_q)
            IDLE: begin
                if (lsu_valid_i && ready_q) begin
                    addr_d   = {lsu_addr_i[31:2], 2'b00};
                    we_d     = lsu_we_i;
                    be_d     = w_be;
                    wdata_d  = w_wdata;
                    size_d   = lsu_size_i;
                    off_d    = lsu_addr_i[1:0];
                    signed_d = lsu_signed_i;
                    if (w_misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    if (we_q || data_rvalid_i) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = we_q ? 32'h0 : w_rsp_data;
                    end else begin
                        state_d = WAIT_RV;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RV: begin
                cnt_d = cnt_inc;
                if (data_rvalid_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = w_rsp_data;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        req_d   = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            req_q    <= 1'b0;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            off_q    <= off_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    assign lsu_ready_o  = ready_q;
    assign lsu_done_o   = done_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;
    assign data_req_o   = req_q;
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : randomized scoreboard bench with a memory responder
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid_i, lsu_ready_o, lsu_we_i, lsu_signed_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_done_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
        .lsu_size_i(lsu_size_i), .lsu_signed_i(lsu_signed_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
        .lsu_rdata_o(lsu_rdata_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model
    function automatic bit ref_mis(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd2) return 4'b0001;
        if (size == 2'd1) return (off == 2'd0) ? 4'b0011 : 4'b0010;
        case (off)
            2'd0: return 4'b1000;
            2'd1: return 4'b1001;
            2'd2: return 4'b1010;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [1:0] off,
                                             input logic sgn, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && lsu_done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'b0, lsu_done_o}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_err", {31'b0, lsu_err_o}, {31'b0, mon_e.err});
                check("done_rdata", lsu_rdata_o, mon_e.rdata);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // rd < 0 means the memory never answers the load.
    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gd, input int rd, input logic [31:0] rdat, input bit rst_mid);
        int unsigned a, g;
        int          n;
        bit          mis;
        exp_t        e;
        n = 0;
        while (!lsu_ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", {31'b0, lsu_ready_o}, 32'h1);
        mis = ref_mis(size, addr[1:0]);
        a   = cyc;
        g   = a + 1 + gd;
        e.err = mis;
        e.rdata = 32'h0;
        if (mis) e.cyc = a + 1;
        else if (we || rd == 0) e.cyc = g + 1;
        else if (rd > 0) e.cyc = g + rd + 1;
        else begin
            e.cyc = g + TO + 1;
            e.err = 1'b1;
        end
        if (!mis && !we && rd >= 0) e.rdata = ref_load(size, addr[1:0], sgn, rdat);
        if (!rst_mid) exp_q.push_back(e);

        lsu_valid_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_signed_i = sgn;
        lsu_addr_i = addr; lsu_wdata_i = wdata;
        @(negedge clk);
        lsu_valid_i = 1'b0; lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
        lsu_size_i = 2'($urandom); lsu_we_i = 1'($urandom);
        if (mis) begin
            check("misaligned_no_req", {31'b0, data_req_o}, 32'h0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            check("req_high", {31'b0, data_req_o}, 32'h1);
            check("req_addr", data_addr_o, {addr[31:2], 2'b00});
            check("req_we", {31'b0, data_we_o}, {31'b0, we});
            check("req_be", {28'b0, data_be_o}, {28'b0, ref_be(size, addr[1:0])});
            if (we) check("req_wdata", data_wdata_o, ref_wdata(size, wdata));
            if (i == gd) begin
                data_gnt_i = 1'b1;
                if (!we && rd == 0) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rdat;
                end
            end else if (!we) begin
                data_rvalid_i = 1'($urandom);
            end
            @(negedge clk);
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
        end
        if (we || rd == 0) return;
        check("wait_no_req", {31'b0, data_req_o}, 32'h0);
        if (rd > 0) begin
            while (cyc < g + rd) @(negedge clk);
            data_rvalid_i = 1'b1; data_rdata_i = rdat;
            @(negedge clk);
            data_rvalid_i = 1'b0; data_rdata_i = $urandom;
        end else if (rst_mid) begin
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst_ready", {31'b0, lsu_ready_o}, 32'h1);
            check("rst_done", {31'b0, lsu_done_o}, 32'h0);
            check("rst_req", {31'b0, data_req_o}, 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (TO + 4) @(negedge clk);
        end
    endtask

    initial begin
        int unsigned r;
        logic [1:0]  sz;
        int          rdl;
        rst_n = 1'b0; lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
        lsu_signed_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready_o", {31'b0, lsu_ready_o}, 32'h1);
        check("rst_done_o", {31'b0, lsu_done_o}, 32'h0);
        check("rst_err_o", {31'b0, lsu_err_o}, 32'h0);
        check("rst_rdata_o", lsu_rdata_o, 32'h0);
        check("rst_req_o", {31'b0, data_req_o}, 32'h0);
        check("rst_addr_o", data_addr_o, 32'h0);
        check("rst_we_o", {31'b0, data_we_o}, 32'h0);
        check("rst_be_o", {28'b0, data_be_o}, 32'h0);
        check("rst_wdata_o", data_wdata_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 2'd2, 1'b0, 32'h0010_0008, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        txn(1'b1, 2'd0, 1'b0, 32'h0010_0003, 32'h1234_56A5, 1, 0, 32'h0, 1'b0);
        txn(1'b0, 2'd0, 1'b1, 32'h0010_0001, 32'h0, 0, 3, 32'h0000_8000, 1'b0);
        txn(1'b0, 2'd1, 1'b0, 32'h0010_0002, 32'h0, 0, 0, 32'h8001_0000, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 32'h0010_0006, 32'h0, 0, 0, 32'h0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 32'h0010_0010, 32'h0, 5, -1, 32'h0, 1'b0);
        txn(1'b0, 2'd2, 1'b0, 32'h0010_0014, 32'h0, 5, TO, 32'hCAFE_F00D, 1'b0);
        txn(1'b0, 2'd1, 1'b1, 32'h0010_0020, 32'h0, 2, -1, 32'h0, 1'b1);

        for (int k = 0; k < 150; k++) begin
            r   = $urandom_range(0, 15);
            sz  = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rdl = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));
            txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), rdl, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (TO + 6) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
